// File: rtl/slice_pkg.sv
// Shared types for the slice reader.
//   mems_t  : two banks (a, b) of ROWS x COLS entries, W bits each, at the
//             default build size; slice_mem declares the same a/b layout
//             at its own parameter sizes.
//   bank_e  : bank select encoding (BANK_A = 0, BANK_B = 1).
//   state_e : reader FSM states.
package slice_pkg;

  localparam int SLICE_W    = 4;
  localparam int SLICE_ROWS = 2;
  localparam int SLICE_COLS = 4;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  typedef struct {
    logic [SLICE_W-1:0] a [SLICE_ROWS][SLICE_COLS];
    logic [SLICE_W-1:0] b [SLICE_ROWS][SLICE_COLS];
  } mems_t;

endpackage

// File: rtl/slice_reader_if.sv
// Read request / read response channels of the slice reader.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. The sender holds valid and its payload
// stable until that edge; ready may change freely and never waits on valid.
//
//   request : req_valid, req_sweep, req_bank, req_row, req_col  (master -> slave)
//             req_ready                                        (slave -> master)
//   response: rsp_valid, rsp_data, rsp_last, rsp_err           (slave -> master)
//             rsp_ready                                        (master -> slave)
interface slice_reader_if #(
  parameter int W    = 4,
  parameter int ROWS = 2,
  parameter int COLS = 4
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic          req_valid;
  logic          req_ready;
  logic          req_sweep;
  logic          req_bank;
  logic [RW-1:0] req_row;
  logic [CW-1:0] req_col;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_last;
  logic          rsp_err;

  modport master (
    output req_valid, req_sweep, req_bank, req_row, req_col, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
  );

  modport slave (
    input  req_valid, req_sweep, req_bank, req_row, req_col, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
  );

endinterface

// File: rtl/slice_mem.sv
// Two-bank entry storage with one write port and one combinational read port.
//   clk, rst_n             : clock, async active-low reset (clears all entries)
//   wr_en/bank/row/col/data: write port; rows >= ROWS are ignored
//   rd_bank/row/col        : read address
//   rd_data, rd_err        : read data (write-first), error for row >= ROWS
module slice_mem
  import slice_pkg::*;
#(
  parameter int W    = 4,
  parameter int ROWS = 2,
  parameter int COLS = 4,
  localparam int RW  = $clog2(ROWS),
  localparam int CW  = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  bank_e         wr_bank,
  input  logic [RW-1:0] wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [W-1:0]  wr_data,
  input  bank_e         rd_bank,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [W-1:0]  rd_data,
  output logic          rd_err
);

  typedef struct {
    logic [W-1:0] a [ROWS][COLS];
    logic [W-1:0] b [ROWS][COLS];
  } bank_pair_t;

  bank_pair_t mem;

  logic wr_ok;
  logic rd_ok;

  // The extra zero bit keeps the compare wide enough to see ROWS itself
  // when ROWS is a power of two.
  assign wr_ok = wr_en && ({1'b0, wr_row} < (RW+1)'(ROWS));
  assign rd_ok = ({1'b0, rd_row} < (RW+1)'(ROWS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          mem.a[r][c] <= '0;
          mem.b[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      if (wr_bank == BANK_A) mem.a[wr_row][wr_col] <= wr_data;
      else                   mem.b[wr_row][wr_col] <= wr_data;
    end
  end

  // A write to the entry being read this cycle is forwarded so the reader
  // captures the new value on the same edge that stores it.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (!rd_ok) begin
      rd_err = 1'b1;
    end else if (wr_ok && (wr_bank == rd_bank) && (wr_row == rd_row) &&
                 (wr_col == rd_col)) begin
      rd_data = wr_data;
    end else if (rd_bank == BANK_A) begin
      rd_data = mem.a[rd_row][rd_col];
    end else begin
      rd_data = mem.b[rd_row][rd_col];
    end
  end

endmodule

// File: rtl/slice_reader.sv
// Slice reader: single-entry reads or a full sweep of both banks, delivered
// through a one-deep response register.
//   clk, rst_n        : clock, async active-low reset
//   wr_*              : write port into the storage (active in any state)
//   bus (slave)       : request channel in, response channel out
//   dbg_state         : current FSM state
module slice_reader
  import slice_pkg::*;
#(
  parameter int W    = 4,
  parameter int ROWS = 2,
  parameter int COLS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic                    wr_bank,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic [W-1:0]            wr_data,
  slice_reader_if.slave           bus,
  output state_e                  dbg_state
);

  localparam int RW      = $clog2(ROWS);
  localparam int CW      = $clog2(COLS);
  localparam int BANK_SZ = ROWS * COLS;
  localparam int N       = 2 * BANK_SZ;
  localparam int CNT_W   = $clog2(N);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(N - 1);

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic         rsp_valid, rsp_last, rsp_err;
  logic [W-1:0] rsp_data;

  logic          can_load, accept, load, load_last;
  bank_e         rd_bank;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [W-1:0]  rd_data;
  logic          rd_err;

  // Sweep index decomposition: counter = bank*BANK_SZ + row*COLS + col.
  // COLS is a power of two, so row/col are plain bit fields of the remainder.
  logic             sw_hi;
  logic [RW+CW-1:0] sw_rem;
  logic [RW-1:0]    sw_row;
  logic [CW-1:0]    sw_col;

  assign sw_hi  = (cnt >= CNT_W'(BANK_SZ));
  assign sw_rem = (RW+CW)'(sw_hi ? (cnt - CNT_W'(BANK_SZ)) : cnt);
  assign sw_row = sw_rem[CW +: RW];
  assign sw_col = sw_rem[CW-1:0];

  // Output register is free when empty or when its content leaves this edge.
  assign can_load      = !rsp_valid || bus.rsp_ready;
  assign bus.req_ready = (state == IDLE) && can_load;
  assign accept        = bus.req_valid && bus.req_ready;

  slice_mem #(.W(W), .ROWS(ROWS), .COLS(COLS)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_bank (bank_e'(wr_bank)),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_bank (rd_bank),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_data (rd_data),
    .rd_err  (rd_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    load      = 1'b0;
    load_last = 1'b0;
    rd_bank   = bank_e'(bus.req_bank);
    rd_row    = bus.req_row;
    rd_col    = bus.req_col;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.req_sweep) begin
            state_nx = SWEEP;
            cnt_nx   = '0;
          end else begin
            load      = 1'b1;
            load_last = 1'b1;
          end
        end
      end
      SWEEP: begin
        rd_bank = sw_hi ? BANK_B : BANK_A;
        rd_row  = sw_row;
        rd_col  = sw_col;
        if (can_load) begin
          load = 1'b1;
          if (cnt == TERM) begin
            load_last = 1'b1;
            state_nx  = IDLE;
            cnt_nx    = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= rd_data;
      rsp_last  <= load_last;
      rsp_err   <= rd_err;
    end else if (rsp_valid && bus.rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_last  = rsp_last;
  assign bus.rsp_err   = rsp_err;
  assign dbg_state     = state;

endmodule
